sync_fifo_wr_arb: RTL and testbench
===================================

Name: sync_fifo_wr_arb

Overview:
Round-robin burst arbiter that shares the write port of one synchronous FIFO between N requesters. Each requester uses a valid/ready/last handshake. The arbiter drives the FIFO wen/data_in directly and never writes while the FIFO reports full. It sits in front of the team's sync FIFO and merges several producer streams into one ordered queue without interleaving bursts.

Parameters:
N_REQ, 4, number of requesters; minimum 2.
MAX_BURST, 4, maximum beats one owner may write before forced rotation; minimum 1.
T, logic [31:0], payload type, identical to the FIFO's T.

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous reset, active-high
req_valid  input  N_REQ  per-requester beat valid
req_last  input  N_REQ  per-requester end-of-burst marker, qualified by valid
req_data  input  N_REQ x T  per-requester payload
req_ready  output  N_REQ  per-requester accept; beat transfers when valid & ready
fifo_full  input  1  FIFO full flag (registered by FIFO)
fifo_wen  output  1  FIFO write enable
fifo_wdata  output  T  FIFO write data
grant_id  output  $clog2(N_REQ)  current/last owner index (registered)
busy  output  1  high while in BURST state

Behaviour:
- Reset (async, rst=1): state=IDLE, rr_ptr=0, beat_cnt=0, grant_id=0, busy=0. While rst=1, req_ready=0 and fifo_wen=0 regardless of inputs.
- fifo_wen = |(req_valid & req_ready). At most one req_ready bit is high per cycle. fifo_wdata = req_data[selected index]; it is don't-care when fifo_wen=0 and is held at the selected requester's data otherwise.
- Zero-latency path: an accepted beat appears on fifo_wen/fifo_wdata in the same cycle. req_ready may depend combinationally on req_valid and fifo_full. req_valid must never depend on req_ready.
- fifo_full=1: all req_ready=0 and fifo_wen=0; state, owner and beat_cnt hold. This is the only flow-control path; the FIFO has no overflow protection.
- IDLE: if fifo_full=0 and any req_valid, select the first valid index searching rr_ptr, rr_ptr+1, ... with wrap modulo N_REQ. Assert its req_ready. The beat is accepted this cycle and grant_id is set to that index.
  - If req_last=1 on that beat or MAX_BURST=1: stay IDLE, rr_ptr = index+1 mod N_REQ.
  - Otherwise go to BURST with beat_cnt=1.
- BURST: only the owner (grant_id) is eligible; all other req_ready=0.
  - Owner valid & !fifo_full: accept the beat and increment beat_cnt.
  - Exit to IDLE with rr_ptr=owner+1 when the accepted beat has req_last=1 or beat_cnt+1 == MAX_BURST.
  - Owner req_valid=0 (bubble): release immediately, go IDLE, rr_ptr=owner+1, no beat this cycle.
- A forced rotation at MAX_BURST with req_last not yet seen is legal. The owner's remaining beats re-arbitrate as a new burst.
- rr_ptr wraps from N_REQ-1 to 0. Index arithmetic uses ($clog2(N_REQ)+1)-bit intermediates with an explicit compare against N_REQ, so N_REQ need not be a power of 2.
- beat_cnt width is $clog2(MAX_BURST)+1. It is reset to 0 on every return to IDLE.
- Reset mid-burst: state returns to IDLE immediately (async). Any partially written burst remains in the FIFO; the bench flushes the FIFO alongside.
- No beat is ever dropped or duplicated. The beats of one burst are contiguous in the FIFO.

Optional Feature:
Macro SYNC_FIFO_WR_ARB_STATS_EN.
- Defined: adds output stall_cnt [15:0]. It increments in any cycle where |req_valid & fifo_full, saturates at 16'hFFFF, and resets to 0 on rst.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
1. N_REQ=4, MAX_BURST=4, FIFO DEPTH=8; reqs 0-3 each hold valid with single-beat bursts (last=1), data=idx -> FIFO receives 0,1,2,3,0,1,... one per cycle; fifo_wen never high with fifo_full=1.
2. Req 2 sends a 6-beat burst (last on beat 6) while req 3 is valid -> beats 1-4 from req 2 contiguous, then req 3 granted, then req 2 beats 5-6.
3. Req 1 bursts 3 beats; full rises after beat 2 for 3 cycles -> req_ready=0 for those cycles, busy=1, grant_id=1 held; beat 3 written when full drops; next grant goes to idx 2 if valid.
4. Owner req 0 drops valid mid-burst after 2 beats while req 1 is valid -> IDLE next cycle, req 1 granted, busy=0 during release cycle.
5. Assert rst for one cycle during a BURST owned by req 3 -> req_ready=0 and fifo_wen=0 during rst; after release rr_ptr=0, so req 0 wins when all valid.
6. With SYNC_FIFO_WR_ARB_STATS_EN: hold full=1 with req_valid=4'b0101 for 10 cycles -> stall_cnt=10; hold for 70000 cycles -> stall_cnt=16'hFFFF.

Source files
------------

// File: rtl/sync_fifo_wr_arb.sv
// sync_fifo_wr_arb: round-robin burst arbiter feeding the write port of one
// synchronous FIFO from N_REQ valid/ready/last producers. A granted owner keeps
// the port until it sends last, hits MAX_BURST beats, or drops valid, so bursts
// land contiguously in the FIFO. Accepted beats reach fifo_wen/fifo_wdata in the
// same cycle.
// Optional: define SYNC_FIFO_WR_ARB_STATS_EN to add the stall_cnt output.
module sync_fifo_wr_arb #(
  parameter int  N_REQ     = 4,
  parameter int  MAX_BURST = 4,
  parameter type T         = logic [31:0]
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ-1:0]           req_last,
  input  T                           req_data [N_REQ],
  output logic [N_REQ-1:0]           req_ready,
  input  logic                       fifo_full,
  output logic                       fifo_wen,
  output T                           fifo_wdata,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy
`ifdef SYNC_FIFO_WR_ARB_STATS_EN
  ,
  output logic [15:0]                stall_cnt
`endif
);

  localparam int IW = $clog2(N_REQ);
  localparam int PW = IW + 1;              // one spare bit so wrap is a plain compare
  localparam int CW = $clog2(MAX_BURST) + 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [CW-1:0]   beat_cnt_q, beat_cnt_d;

  logic            rr_found;
  logic [IW-1:0]   rr_sel;
  logic [PW-1:0]   idx_w;
  logic [IW-1:0]   sel_idx;

  // owner+1 with wrap to 0; works for non-power-of-2 N_REQ
  function automatic logic [IW-1:0] inc_idx(input logic [IW-1:0] i);
    logic [PW-1:0] t;
    t = {1'b0, i} + PW'(1);
    if (t >= PW'(N_REQ)) t = '0;
    return t[IW-1:0];
  endfunction

  // round-robin search: first valid index starting at rr_ptr, wrapping mod N_REQ
  always_comb begin
    rr_found = 1'b0;
    rr_sel   = rr_ptr_q;
    idx_w    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx_w = {1'b0, rr_ptr_q} + PW'(k);
      if (idx_w >= PW'(N_REQ)) idx_w = idx_w - PW'(N_REQ);
      if (!rr_found && req_valid[idx_w[IW-1:0]]) begin
        rr_found = 1'b1;
        rr_sel   = idx_w[IW-1:0];
      end
    end
  end

  // only the owner is eligible mid-burst; otherwise the round-robin pick
  assign sel_idx    = (state_q == BURST) ? grant_q : rr_sel;
  assign fifo_wdata = req_data[sel_idx];
  assign fifo_wen   = |(req_valid & req_ready);
  assign grant_id   = grant_q;
  assign busy       = (state_q == BURST);

  // next-state, handshake and pointer update; full or reset freezes everything
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    beat_cnt_d = beat_cnt_q;
    req_ready  = '0;
    if (!rst && !fifo_full) begin
      case (state_q)
        IDLE: begin
          if (rr_found) begin
            req_ready[rr_sel] = 1'b1;
            grant_d           = rr_sel;
            if (req_last[rr_sel] || MAX_BURST == 1) begin
              rr_ptr_d = inc_idx(rr_sel);
            end else begin
              state_d    = BURST;
              beat_cnt_d = CW'(1);
            end
          end
        end
        BURST: begin
          if (req_valid[grant_q]) begin
            req_ready[grant_q] = 1'b1;
            if (req_last[grant_q] || (beat_cnt_q + CW'(1) == CW'(MAX_BURST))) begin
              state_d    = IDLE;
              beat_cnt_d = '0;
              rr_ptr_d   = inc_idx(grant_q);
            end else begin
              beat_cnt_d = beat_cnt_q + CW'(1);
            end
          end else begin
            // bubble from the owner: give the port up rather than stall others
            state_d    = IDLE;
            beat_cnt_d = '0;
            rr_ptr_d   = inc_idx(grant_q);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef SYNC_FIFO_WR_ARB_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // saturating count of cycles where someone wants to write but the FIFO is full
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (|req_valid && fifo_full && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // stall counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_sync_fifo_wr_arb.sv
// Directed bench for sync_fifo_wr_arb (N_REQ=4, MAX_BURST=4). Inputs change 1
// time unit after the rising edge; outputs are checked on the falling edge.
module tb_sync_fifo_wr_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [31:0] req_data [4];
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_wen;
  logic [31:0] fifo_wdata;
  logic [1:0]  grant_id;
  logic        busy;
`ifdef SYNC_FIFO_WR_ARB_STATS_EN
  logic [15:0] stall_cnt;
`endif

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sync_fifo_wr_arb #(.N_REQ(4), .MAX_BURST(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wen   (fifo_wen),
    .fifo_wdata (fifo_wdata),
    .grant_id   (grant_id),
    .busy       (busy)
`ifdef SYNC_FIFO_WR_ARB_STATS_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one cycle in which requester idx must be accepted
  task automatic chk_beat(input string tag, input int idx, input logic exp_busy,
                          input logic [1:0] exp_grant);
    @(negedge clk);
    check({tag, ".wen"},   32'(fifo_wen), 32'd1);
    check({tag, ".ready"}, 32'(req_ready), 32'(1 << idx));
    check({tag, ".data"},  fifo_wdata, req_data[idx]);
    check({tag, ".busy"},  32'(busy), 32'(exp_busy));
    check({tag, ".grant"}, 32'(grant_id), 32'(exp_grant));
    tick();
  endtask

  // one cycle in which nothing may be written
  task automatic chk_none(input string tag, input logic exp_busy, input logic [1:0] exp_grant);
    @(negedge clk);
    check({tag, ".wen"},   32'(fifo_wen), 32'd0);
    check({tag, ".ready"}, 32'(req_ready), 32'd0);
    check({tag, ".busy"},  32'(busy), 32'(exp_busy));
    check({tag, ".grant"}, 32'(grant_id), 32'(exp_grant));
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 4'hF;
    req_last  = 4'hF;
    fifo_full = 1'b0;
    for (int i = 0; i < 4; i++) req_data[i] = 32'(i);

    // reset: no handshake even with every requester valid
    #2;
    check("rst.wen",   32'(fifo_wen), 32'd0);
    check("rst.ready", 32'(req_ready), 32'd0);
    check("rst.busy",  32'(busy), 32'd0);
    check("rst.grant", 32'(grant_id), 32'd0);
`ifdef SYNC_FIFO_WR_ARB_STATS_EN
    check("rst.stall", 32'(stall_cnt), 32'd0);
`endif
    tick();
    rst = 1'b0;

    // 1: all valid, single-beat bursts -> 0,1,2,3,0,1,2,3
    for (int k = 0; k < 8; k++)
      chk_beat($sformatf("t1.b%0d", k), k % 4, 1'b0, (k == 0) ? 2'd0 : 2'((k - 1) % 4));
    fifo_full = 1'b1;
    chk_none("t1.full0", 1'b0, 2'd3);
    chk_none("t1.full1", 1'b0, 2'd3);
    fifo_full = 1'b0;
    req_valid = 4'h0;
    for (int i = 0; i < 4; i++) req_data[i] = 32'h100 * (i + 1);

    // 2: req2 six-beat burst, req3 single beats; rr_ptr=0
    req_valid = 4'b1100;
    req_last  = 4'b1000;
    chk_beat("t2.b1", 2, 1'b0, 2'd3);
    chk_beat("t2.b2", 2, 1'b1, 2'd2);
    chk_beat("t2.b3", 2, 1'b1, 2'd2);
    chk_beat("t2.b4", 2, 1'b1, 2'd2);
    chk_beat("t2.r3", 3, 1'b0, 2'd2);
    req_valid = 4'b0100;
    chk_beat("t2.b5", 2, 1'b0, 2'd3);
    req_last  = 4'b0100;
    chk_beat("t2.b6", 2, 1'b1, 2'd2);
    req_valid = 4'h0;

    // 3: req1 three-beat burst, full for 3 cycles after beat 2; rr_ptr=3
    req_valid = 4'b0110;
    req_last  = 4'b0100;
    chk_beat("t3.b1", 1, 1'b0, 2'd2);
    chk_beat("t3.b2", 1, 1'b1, 2'd1);
    fifo_full = 1'b1;
    chk_none("t3.f0", 1'b1, 2'd1);
    chk_none("t3.f1", 1'b1, 2'd1);
    chk_none("t3.f2", 1'b1, 2'd1);
    fifo_full = 1'b0;
    req_last  = 4'b0110;
    chk_beat("t3.b3", 1, 1'b1, 2'd1);
    chk_beat("t3.r2", 2, 1'b0, 2'd1);
    req_valid = 4'h0;

    // 4: owner req0 drops valid after 2 beats while req1 waits; rr_ptr=3
    req_valid = 4'b0011;
    req_last  = 4'b0000;
    chk_beat("t4.b1", 0, 1'b0, 2'd2);
    chk_beat("t4.b2", 0, 1'b1, 2'd0);
    req_valid = 4'b0010;
    req_last  = 4'b0010;
    chk_none("t4.bubble", 1'b1, 2'd0);
    chk_beat("t4.r1", 1, 1'b0, 2'd0);
    req_valid = 4'h0;

    // 5: reset during a req3 burst; rr_ptr=2
    req_valid = 4'b1000;
    req_last  = 4'b0000;
    chk_beat("t5.b1", 3, 1'b0, 2'd1);
    chk_beat("t5.b2", 3, 1'b1, 2'd3);
    rst       = 1'b1;
    req_valid = 4'hF;
    req_last  = 4'b0111;
    chk_none("t5.rst", 1'b0, 2'd0);
    rst       = 1'b0;
    chk_beat("t5.r0", 0, 1'b0, 2'd0);
    req_valid = 4'h0;

`ifdef SYNC_FIFO_WR_ARB_STATS_EN
    // 6: stall counter; cleared by the reset in step 5, no stalls since
    fifo_full = 1'b1;
    req_valid = 4'b0101;
    for (int k = 0; k < 10; k++) tick();
    @(negedge clk);
    check("t6.stall10", 32'(stall_cnt), 32'd10);
    check("t6.wen",     32'(fifo_wen), 32'd0);
    for (int k = 0; k < 65530; k++) tick();
    @(negedge clk);
    check("t6.sat", 32'(stall_cnt), 32'h0000FFFF);
    fifo_full = 1'b0;
    req_valid = 4'h0;
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
